// File: rtl/hamming74_encoder.sv
// Purpose : Sequential Hamming(7,4) encoder, one parity bit per cycle, even/odd parity per word.
// Latency : out_valid rises on the 3rd rising edge after the accepting edge; min 5 cycles/word.
// Backpr. : holds code_out/out_valid in DONE until out_ready; in_ready low while a word is in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake for data_in (d3..d0) and mode (1=even, 0=odd)
//   out_valid/out_ready output handshake for code_out (bit index = Hamming position - 1)
//   word_cnt            saturating count of delivered codewords (CNT_W bits)
// Optional macro HAMMING_ERR_INJECT_EN adds inj_en/inj_pos: flip codeword bit inj_pos-1
// (inj_pos=0 means no flip), both sampled with the accepted word.
module hamming74_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       data_in,
   input  logic             mode,
`ifdef HAMMING_ERR_INJECT_EN
   input  logic             inj_en,
   input  logic [2:0]       inj_pos,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       code_out,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      P4   = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] data_q;
   logic       mode_q;
   logic       p1_q, p2_q;
   logic       odd_inv;
   logic       p4;
   logic [6:0] codeword;
   logic [6:0] inj_mask;

`ifdef HAMMING_ERR_INJECT_EN
   logic       inj_en_q;
   logic [2:0] inj_pos_q;
`endif

   // Gating with rst_n keeps in_ready low for the whole reset, not just after the first edge.
   assign in_ready = (state_q == IDLE) && rst_n;

   // Odd parity is even parity inverted; always taken from the latched mode.
   assign odd_inv = ~mode_q;
   assign p4      = data_q[1] ^ data_q[2] ^ data_q[3] ^ odd_inv;

   always_comb begin
      codeword = {data_q[3], data_q[2], data_q[1], p4, data_q[0], p2_q, p1_q};
      inj_mask = 7'd0;
`ifdef HAMMING_ERR_INJECT_EN
      if (inj_en_q && (inj_pos_q != 3'd0)) begin
         inj_mask = 7'd1 << (inj_pos_q - 3'd1);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid && in_ready) state_d = P1;
         P1:      state_d = P2;
         P2:      state_d = P4;
         P4:      state_d = DONE;
         DONE:    if (out_valid && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= 4'd0;
         mode_q    <= 1'b0;
         p1_q      <= 1'b0;
         p2_q      <= 1'b0;
         code_out  <= 7'd0;
         out_valid <= 1'b0;
         word_cnt  <= '0;
`ifdef HAMMING_ERR_INJECT_EN
         inj_en_q  <= 1'b0;
         inj_pos_q <= 3'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  data_q <= data_in;
                  mode_q <= mode;
`ifdef HAMMING_ERR_INJECT_EN
                  inj_en_q  <= inj_en;
                  inj_pos_q <= inj_pos;
`endif
               end
            end
            P1: p1_q <= data_q[0] ^ data_q[1] ^ data_q[3] ^ odd_inv;
            P2: p2_q <= data_q[0] ^ data_q[2] ^ data_q[3] ^ odd_inv;
            P4: begin
               code_out  <= codeword ^ inj_mask;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (word_cnt != {CNT_W{1'b1}}) begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming74_encoder.sv
// Purpose : self-checking bench for hamming74_encoder (scoreboard + positional parity model).
// Latency : checks out_valid rises exactly 3 edges after each accepting edge.
// Backpr. : exercises random and long out_ready stalls, busy-time in_valid, mid-word resets.
module tb_hamming74_encoder;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       data_in;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [6:0]       code_out;
   logic [CNT_W-1:0] word_cnt;
`ifdef HAMMING_ERR_INJECT_EN
   logic             inj_en;
   logic [2:0]       inj_pos;
`endif

   hamming74_encoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .mode      (mode),
`ifdef HAMMING_ERR_INJECT_EN
      .inj_en    (inj_en),
      .inj_pos   (inj_pos),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .code_out  (code_out),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         exp_cnt  = 0;
   logic       prev_ov  = 1'b0;
   logic       rand_rdy = 1'b0;
   logic [6:0] exp_q[$];
   int         acc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference: place data at Hamming positions 3,5,6,7; parity bit at position 2^k covers
   // every position whose index has bit k set. Even parity makes the covered group even.
   function automatic logic [6:0] model(input logic [3:0] d, input logic m,
                                        input logic ie, input logic [2:0] ip);
      logic [7:0] pos;
      int         dpos[4];
      int         ones;
      logic [6:0] cw;
      dpos = '{3, 5, 6, 7};
      pos  = '0;
      for (int i = 0; i < 4; i++) pos[dpos[i]] = d[i];
      for (int k = 0; k < 3; k++) begin
         ones = 0;
         for (int p = 1; p < 8; p++)
            if (((p >> k) & 1) == 1 && p != (1 << k)) ones += int'(pos[p]);
         pos[1 << k] = m ? ((ones % 2) == 1) : ((ones % 2) == 0);
      end
      cw = pos[7:1];
      if (ie && ip != 3'd0) cw[ip - 3'd1] = ~cw[ip - 3'd1];
      return cw;
   endfunction

   // Scoreboard: input side pushes expectations on acceptance, output side pops on handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
`ifdef HAMMING_ERR_INJECT_EN
            exp_q.push_back(model(data_in, mode, inj_en, inj_pos));
`else
            exp_q.push_back(model(data_in, mode, 1'b0, 3'd0));
`endif
            acc_q.push_back(cyc + 4);
         end
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) fail_now("latency: out_valid with no word in flight");
            else check("latency", cyc, acc_q.pop_front());
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("codeword: output with empty scoreboard");
            else check("codeword", code_out, exp_q.pop_front());
            check("word_cnt", word_cnt, exp_cnt);
            if (exp_cnt != CNT_MAX) exp_cnt++;
         end
      end
      prev_ov = out_valid;
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Present a word, wait (bounded) for acceptance, then scramble inputs to prove they are latched.
   task automatic send(input logic [3:0] d, input logic m);
      bit taken = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in  = d;
      mode     = m;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            taken = 1;
            break;
         end
      end
      if (!taken) fail_now("send: word never accepted");
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = 4'($urandom);
      mode     = 1'($urandom);
   endtask

   task automatic wait_out();
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      if (!seen) fail_now("wait_out: out_valid never rose");
   endtask

   task automatic directed(input logic [3:0] d, input logic m, input logic [6:0] exp);
      send(d, m);
      wait_out();
      check("directed code_out", code_out, exp);
   endtask

   task automatic flush_model();
      exp_q.delete();
      acc_q.delete();
      exp_cnt = 0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      data_in   = 4'd0;
      mode      = 1'b0;
      out_ready = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
      inj_en    = 1'b0;
      inj_pos   = 3'd0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", in_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset code_out", code_out, 0);
      check("reset word_cnt", word_cnt, 0);
      rst_n = 1'b1;
      #1;
      check("in_ready after reset", in_ready, 1);

      // Directed vectors with immediate downstream acceptance.
      out_ready = 1'b1;
      directed(4'b1011, 1'b1, 7'h55);
      @(posedge clk); #1;
      check("word_cnt after first", word_cnt, 1);
      directed(4'b1011, 1'b0, 7'h5E);
      directed(4'h0, 1'b0, 7'h0B);
      directed(4'hF, 1'b1, 7'h7F);

      // Long backpressure: output held, new word refused until release.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(4'b1011, 1'b1);
      wait_out();
      @(posedge clk); #1;
      in_valid = 1'b1;
      data_in  = 4'h3;
      mode     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall code_out", code_out, 7'h55);
         check("stall out_valid", out_valid, 1);
         check("stall in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      directed(4'h3, 1'b0, 7'h15);

`ifdef HAMMING_ERR_INJECT_EN
      inj_en  = 1'b1;
      inj_pos = 3'd3;
      directed(4'b1011, 1'b1, 7'h51);
      inj_pos = 3'd0;
      directed(4'b1011, 1'b1, 7'h55);
      inj_en  = 1'b0;
`endif

      // Reset while computing p2: everything cleared at once.
      send(4'h9, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midword reset out_valid", out_valid, 0);
      check("midword reset word_cnt", word_cnt, 0);
      check("midword reset in_ready", in_ready, 0);
      flush_model();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("in_ready after midword reset", in_ready, 1);

      // Reset while presenting a stalled codeword: out_valid drops asynchronously.
      out_ready = 1'b0;
      send(4'h6, 1'b0);
      wait_out();
      #2;
      rst_n = 1'b0;
      #1;
      check("done reset out_valid", out_valid, 0);
      check("done reset code_out", code_out, 0);
      flush_model();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Random traffic with random backpressure; counter saturates well before the end.
      rand_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
`ifdef HAMMING_ERR_INJECT_EN
         inj_en  = 1'($urandom);
         inj_pos = 3'($urandom);
`endif
         send(4'($urandom), 1'($urandom));
      end
      @(posedge clk);
      rand_rdy = 1'b0;
      #2;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard drained", exp_q.size(), 0);
      check("word_cnt saturated", word_cnt, CNT_MAX);
      check("idle in_ready", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
